// File: rtl/pos_update_sched_pkg.sv
// Shared types and constants for the position-update scheduler.
package pos_update_sched_pkg;

  localparam int unsigned PosW       = 12;
  localparam int unsigned HActiveDef = 800;
  localparam int unsigned VActiveDef = 600;
  localparam int unsigned RectWDef   = 48;
  localparam int unsigned RectHDef   = 64;

  typedef enum logic [1:0] {StIdle, StHold, StCommit} state_e;

  function automatic logic [PosW-1:0] clamp_pos(logic [PosW-1:0] v, logic [PosW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/pos_update_sched_if.sv
// Request/acknowledge bundle shared by the two position requesters and the scheduler.
interface pos_update_sched_if;
  import pos_update_sched_pkg::*;

  logic            req0;
  logic            req1;
  logic [PosW-1:0] xpos0_in;
  logic [PosW-1:0] ypos0_in;
  logic [PosW-1:0] xpos1_in;
  logic [PosW-1:0] ypos1_in;
  logic            ack0;
  logic            ack1;

  modport master (
    output req0, req1, xpos0_in, ypos0_in, xpos1_in, ypos1_in,
    input  ack0, ack1
  );

  modport slave (
    input  req0, req1, xpos0_in, ypos0_in, xpos1_in, ypos1_in,
    output ack0, ack1
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer moves only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when req1 won last, so req0 takes the next tie.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/pos_update_sched.sv
// Captures requested object positions and commits them only at a frame boundary.
// Optional build macro POS_CLAMP_EN clamps captured positions to keep the object on screen.
module pos_update_sched
  import pos_update_sched_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned RECT_W   = RectWDef,
  parameter int unsigned RECT_H   = RectHDef
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vblnk_in,
  pos_update_sched_if.slave     bus,
  output logic [PosW-1:0]       xpos,
  output logic [PosW-1:0]       ypos,
  output logic                  pending,
  output logic [7:0]            commit_cnt
);

  if (RECT_W > H_ACTIVE || RECT_H > V_ACTIVE) begin : g_bad_geom
    $error("object does not fit on the active screen");
  end

  state_e          state_q;
  logic            vblnk_d;
  logic [1:0]      ack_q;
  logic            pending_q;
  logic [7:0]      cnt_q;
  logic [PosW-1:0] cap_x_q, cap_y_q, xpos_q, ypos_q;
  logic [PosW-1:0] win_x, win_y, cap_x, cap_y;
  logic [1:0]      gnt;
  logic            frame_rise;

  assign frame_rise = vblnk_in & ~vblnk_d;

  rr_arb2 u_arb (
    .clk (pclk),
    .rst (rst),
    .en  (state_q == StIdle),
    .req ({bus.req1, bus.req0}),
    .gnt (gnt)
  );

  always_comb begin
    win_x = gnt[1] ? bus.xpos1_in : bus.xpos0_in;
    win_y = gnt[1] ? bus.ypos1_in : bus.ypos0_in;
`ifdef POS_CLAMP_EN
    cap_x = clamp_pos(win_x, PosW'(H_ACTIVE - RECT_W));
    cap_y = clamp_pos(win_y, PosW'(V_ACTIVE - RECT_H));
`else
    cap_x = win_x;
    cap_y = win_y;
`endif
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= StIdle;
      vblnk_d   <= 1'b0;
      ack_q     <= 2'b00;
      pending_q <= 1'b0;
      cnt_q     <= 8'd0;
      cap_x_q   <= '0;
      cap_y_q   <= '0;
      xpos_q    <= '0;
      ypos_q    <= '0;
    end else begin
      vblnk_d <= vblnk_in;
      ack_q   <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (|gnt) begin
            ack_q     <= gnt;
            cap_x_q   <= cap_x;
            cap_y_q   <= cap_y;
            pending_q <= 1'b1;
            state_q   <= StHold;
          end
        end
        StHold: begin
          // Commit registers load on entry to StCommit so the new position
          // shows one cycle after the boundary cycle.
          if (frame_rise) begin
            xpos_q  <= cap_x_q;
            ypos_q  <= cap_y_q;
            cnt_q   <= cnt_q + 8'd1;
            state_q <= StCommit;
          end
        end
        StCommit: begin
          pending_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: begin
          pending_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign pending    = pending_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_pos_update_sched.sv
// Scoreboard bench for pos_update_sched: expected commits queued at request time.
module tb_pos_update_sched;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        vblnk = 1'b0;
  logic [11:0] xpos, ypos;
  logic        pending;
  logic [7:0]  commit_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  pos_t exp_q[$];
  logic [7:0] cnt_prev = 8'd0;

  pos_update_sched_if bus ();

  pos_update_sched dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk),
    .bus        (bus.slave),
    .xpos       (xpos),
    .ypos       (ypos),
    .pending    (pending),
    .commit_cnt (commit_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_pos(input int v, input int lim);
`ifdef POS_CLAMP_EN
    return (v > lim) ? 12'(lim) : 12'(v);
`else
    return 12'(v);
`endif
  endfunction

  // Commit monitor: every commit_cnt step pops one expected position.
  always @(posedge pclk) begin
    #1;
    if (bus.ack0 || bus.ack1) check_val("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
    if (!rst && commit_cnt != cnt_prev) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_commit", 1, 0);
      end else begin
        pos_t e;
        e = exp_q.pop_front();
        check_val("commit_x", 32'(xpos), 32'(e.x));
        check_val("commit_y", 32'(ypos), 32'(e.y));
      end
    end
    cnt_prev = commit_cnt;
  end

  task automatic wait_ack(input int which, input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge pclk);
      #1;
      if ((which == 0 && bus.ack0) || (which == 1 && bus.ack1)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_req(input int which, input int x, input int y, input bit push);
    bit got;
    pos_t e;
    @(negedge pclk);
    if (which == 0) begin
      bus.xpos0_in = 12'(x); bus.ypos0_in = 12'(y); bus.req0 = 1'b1;
    end else begin
      bus.xpos1_in = 12'(x); bus.ypos1_in = 12'(y); bus.req1 = 1'b1;
    end
    if (push) begin
      e.x = exp_pos(x, 752);
      e.y = exp_pos(y, 536);
      exp_q.push_back(e);
    end
    wait_ack(which, 1, got);
    check_val("ack_next_cycle", 32'(got), 1);
    if (which == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
    @(posedge pclk);
    #1;
    check_val("ack_one_cycle", 32'(which == 0 ? bus.ack0 : bus.ack1), 0);
  endtask

  task automatic frame();
    @(negedge pclk);
    vblnk = 1'b1;
    repeat (3) @(negedge pclk);
    vblnk = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic pulse_rst();
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  initial begin
    bit got;
    pos_t e;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.xpos0_in = '0; bus.ypos0_in = '0; bus.xpos1_in = '0; bus.ypos1_in = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    check_val("rst_xpos", 32'(xpos), 0);
    check_val("rst_ypos", 32'(ypos), 0);
    check_val("rst_pending", 32'(pending), 0);
    check_val("rst_cnt", 32'(commit_cnt), 0);
    check_val("rst_acks", 32'({bus.ack1, bus.ack0}), 0);

    // Single request, commit one cycle after the boundary cycle
    do_req(0, 100, 200, 1'b1);
    check_val("pend_hold", 32'(pending), 1);
    @(negedge pclk);
    vblnk = 1'b1;
    check_val("xpos_pre_commit", 32'(xpos), 0);
    @(posedge pclk);
    #1;
    check_val("xpos_commit", 32'(xpos), 100);
    check_val("ypos_commit", 32'(ypos), 200);
    check_val("cnt_commit", 32'(commit_cnt), 1);
    check_val("pend_commit", 32'(pending), 1);
    repeat (2) @(negedge pclk);
    vblnk = 1'b0;
    @(negedge pclk);
    check_val("pend_idle", 32'(pending), 0);

    // Tie after reset goes to req0; held req1 waits through HOLD
    pulse_rst();
    @(negedge pclk);
    bus.xpos0_in = 12'd10; bus.ypos0_in = 12'd11;
    bus.xpos1_in = 12'd20; bus.ypos1_in = 12'd21;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    e.x = 12'd10; e.y = 12'd11; exp_q.push_back(e);
    e.x = 12'd20; e.y = 12'd21; exp_q.push_back(e);
    @(posedge pclk);
    #1;
    check_val("tie_ack0", 32'(bus.ack0), 1);
    check_val("tie_ack1", 32'(bus.ack1), 0);
    bus.req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk);
      #1;
      check_val("no_ack_in_hold", 32'(bus.ack1), 0);
    end
    @(negedge pclk);
    vblnk = 1'b1;
    wait_ack(1, 3, got);
    check_val("ack1_after_commit", 32'(got), 1);
    check_val("cnt_after_tie", 32'(commit_cnt), 1);
    bus.req1 = 1'b0;
    @(negedge pclk);
    vblnk = 1'b0;
    check_val("pend_second", 32'(pending), 1);
    frame();
    check_val("cnt_two", 32'(commit_cnt), 2);

    // Out-of-range position
    do_req(0, 900, 700, 1'b1);
    frame();
    check_val("clamp_x", 32'(xpos), 32'(exp_pos(900, 752)));
    check_val("clamp_y", 32'(ypos), 32'(exp_pos(700, 536)));

    // Reset during HOLD drops the capture
    do_req(0, 50, 60, 1'b0);
    pulse_rst();
    check_val("rsthold_x", 32'(xpos), 0);
    check_val("rsthold_y", 32'(ypos), 0);
    check_val("rsthold_pend", 32'(pending), 0);
    frame();
    check_val("rsthold_cnt", 32'(commit_cnt), 0);
    check_val("rsthold_pend2", 32'(pending), 0);

    // Request and boundary in the same IDLE cycle: capture only
    @(negedge pclk);
    bus.xpos0_in = 12'd321; bus.ypos0_in = 12'd123; bus.req0 = 1'b1; vblnk = 1'b1;
    e.x = 12'd321; e.y = 12'd123; exp_q.push_back(e);
    @(posedge pclk);
    #1;
    check_val("same_ack", 32'(bus.ack0), 1);
    bus.req0 = 1'b0;
    repeat (3) @(negedge pclk);
    check_val("same_no_commit", 32'(commit_cnt), 0);
    check_val("same_pend", 32'(pending), 1);
    check_val("same_xpos", 32'(xpos), 0);
    vblnk = 1'b0;
    frame();
    check_val("same_cnt", 32'(commit_cnt), 1);

    // 256 commits wrap the counter
    pulse_rst();
    for (int i = 0; i < 256; i++) begin
      do_req(i % 2, i, (2 * i) % 600, 1'b1);
      frame();
    end
    check_val("wrap_cnt", 32'(commit_cnt), 0);
    check_val("wrap_pend", 32'(pending), 0);
    check_val("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pos_update_sched.md
POS_UPDATE_SCHED -- requirements
Module: pos_update_sched

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-003 Parameter RECT_W, 48, drawn object width in pixels.
REQ-004 Parameter RECT_H, 64, drawn object height in lines.
REQ-005 Port pclk  in  1  pixel clock; the block's only clock.
REQ-006 Port rst  in  1  reset; synchronous, active-high.
REQ-007 Port vblnk_in  in  1  vertical blank from the timing pipeline.
REQ-008 Port req0 / req1  in  1 each  position-update request, level, held until acked.
REQ-009 Port xpos0_in, ypos0_in, xpos1_in, ypos1_in  in  12 each  requested position per requester.
REQ-010 Port ack0 / ack1  out  1 each  one-cycle capture acknowledge.
REQ-011 Port xpos / ypos  out  12 each  committed object position, feeds the rectangle draw stage.
REQ-012 Port pending  out  1  high while a captured update awaits commit.
REQ-013 Port commit_cnt  out  8  count of commits, wraps 255 -> 0.

Function
REQ-014 FSM states: IDLE, HOLD, COMMIT.
REQ-015 IDLE: if any req high, capture the winner's x/y, assert its ack for exactly one cycle on the next edge, go to HOLD.
REQ-016 Arbitration: round-robin between req0 and req1; the requester not granted last wins a tie; after reset req0 wins the first tie.
REQ-017 At most one ack per cycle; ack never asserted while in HOLD or COMMIT (requesters stall).
REQ-018 Frame boundary = rising edge of vblnk_in, from a registered copy vblnk_d (vblnk_in & ~vblnk_d).
REQ-019 HOLD: on frame boundary go to COMMIT; otherwise stay, pending = 1.
REQ-020 COMMIT: load xpos/ypos from captured values, increment commit_cnt modulo 256, go to IDLE; the new position is visible one cycle after the boundary cycle.
REQ-021 Request and frame boundary in the same IDLE cycle: capture only; commit occurs at the next frame boundary.
REQ-022 Frame boundary in IDLE or COMMIT: ignored, nothing lost or duplicated.
REQ-023 xpos/ypos change only in COMMIT, so they are stable for the whole active frame.
REQ-024 pending = 1 in HOLD and COMMIT, 0 in IDLE.

Reset
REQ-025 On rst: state IDLE, xpos = 0, ypos = 0, ack0 = ack1 = 0, pending = 0, commit_cnt = 0, vblnk_d = 0, round-robin pointer favours req0.
REQ-026 rst mid-HOLD discards the captured update; no commit follows.

Configuration
REQ-027 Macro POS_CLAMP_EN: when defined, captured x is clamped to H_ACTIVE-RECT_W and y to V_ACTIVE-RECT_H at capture time.
REQ-028 Without POS_CLAMP_EN, captured values pass through unmodified (12-bit, no wrap or saturation).

Structure
REQ-029 Shared package holds the state enum, the 12-bit position width constant and default screen/object constants.
REQ-030 One sub-module, rr_arb2: two request inputs, one-hot grant, last-grant pointer updated only on an actual grant.

Verification
REQ-031 req0 with (100,200) mid-frame -> ack0 pulse next cycle; pending = 1; xpos/ypos = (100,200) one cycle after the next vblnk rise; commit_cnt = 1.
REQ-032 req0 and req1 together, twice across two frames -> first grant req0, second grant req1; never both acks in one cycle.
REQ-033 req1 held high during HOLD -> no ack1 until after COMMIT; ack1 then follows within one cycle.
REQ-034 With POS_CLAMP_EN, request (900,700) -> commit (752,536); without it -> commit (900,700).
REQ-035 rst during HOLD after capture of (50,60) -> outputs (0,0), pending = 0, no commit at the following vblnk rise.
REQ-036 256 consecutive frame commits -> commit_cnt returns to 0.
